// File: rtl/int_ctrl_arb.sv
// Interrupt controller: synchronises and latches interrupt sources, arbitrates by
// fixed priority and merges the winning request with the EX-stage exception.
module int_ctrl_arb #(
  parameter int                           NUM_SRC     = 3,
  parameter int                           CAUSE_W     = 5,
  parameter logic [NUM_SRC*CAUSE_W-1:0]   CAUSE_TABLE = {5'd7, 5'd3, 5'd11},
  parameter logic [NUM_SRC-1:0]           EDGE_MASK   = '0,
  parameter int                           SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic [NUM_SRC-1:0] irq_en_i,
  input  logic               glb_en_i,
  input  logic               inst_valid_i,
  input  logic               ex_exception_flag_i,
  input  logic [CAUSE_W-1:0] ex_exception_cause_i,
  input  logic               trap_taken_i,
  input  logic               trap_ret_i,
  output logic               ex_exception_flag_o,
  output logic [CAUSE_W-1:0] ex_exception_cause_o,
  output logic [NUM_SRC-1:0] int_pending_o,
  output logic               in_service_o
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   lat_idx;
  logic [CAUSE_W-1:0] lat_cause;
  logic [NUM_SRC-1:0] irq_s;
  logic [NUM_SRC-1:0] irq_prev;
  logic [NUM_SRC-1:0] edge_pend;
  logic [NUM_SRC-1:0] edge_clr;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] eligible;
  logic               any_elig;
  logic [IDX_W-1:0]   win_idx;
  logic [CAUSE_W-1:0] win_cause;
  logic               req;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign irq_s = irq_i;
    end else begin : g_sync
      logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= irq_i;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign irq_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // An edge-latched bit is only released once its own interrupt has been taken.
  always_comb begin
    edge_clr = '0;
    for (int k = 0; k < NUM_SRC; k++)
      edge_clr[k] = (state == REQ) && trap_taken_i && (lat_idx == IDX_W'(k));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev  <= '0;
      edge_pend <= '0;
    end else begin
      irq_prev <= irq_s;
      for (int k = 0; k < NUM_SRC; k++) begin
        if (EDGE_MASK[k])
          edge_pend[k] <= (irq_s[k] & ~irq_prev[k]) | (edge_pend[k] & ~edge_clr[k]);
        else
          edge_pend[k] <= 1'b0;
      end
    end
  end

  assign pend     = (EDGE_MASK & edge_pend) | (~EDGE_MASK & irq_s);
  assign eligible = pend & irq_en_i & {NUM_SRC{glb_en_i}};
  assign any_elig = |eligible;

  always_comb begin
    win_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (eligible[k]) win_idx = IDX_W'(k);
  end

  assign win_cause = CAUSE_TABLE[int'(win_idx) * CAUSE_W +: CAUSE_W];

  // A coincident trap_taken beats withdraw and re-arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_idx   <= '0;
      lat_cause <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_elig) begin
            lat_idx   <= win_idx;
            lat_cause <= win_cause;
            state     <= REQ;
          end
        end
        REQ: begin
          if (trap_taken_i) begin
            state <= SERVICE;
          end else if (!any_elig) begin
            state <= IDLE;
          end else if (win_idx != lat_idx) begin
            lat_idx   <= win_idx;
            lat_cause <= win_cause;
          end
        end
        SERVICE: begin
          if (trap_ret_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req                  = (state == REQ);
  assign ex_exception_flag_o  = rst_n & inst_valid_i & (ex_exception_flag_i | req);
  assign ex_exception_cause_o = !rst_n ? '0 : (req ? lat_cause : ex_exception_cause_i);
  assign int_pending_o        = pend & {NUM_SRC{rst_n}};
  assign in_service_o         = (state == SERVICE);

endmodule

// File: tb/tb_int_ctrl_arb.sv
// Randomised and directed bench for int_ctrl_arb with a queue-based scoreboard
// fed by a behavioural model of the interrupt rules.
module tb_int_ctrl_arb;

  localparam int         N  = 3;
  localparam int         CW = 5;
  localparam int         S  = 2;
  localparam logic [2:0] EM = 3'b010;

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_SVC  = 2;

  logic          clk = 1'b1;
  logic          rst_n = 1'b0;
  logic [N-1:0]  irq = '0;
  logic [N-1:0]  en = '0;
  logic          glb = 1'b0;
  logic          iv = 1'b0;
  logic          exf = 1'b0;
  logic [CW-1:0] exc = '0;
  logic          taken = 1'b0;
  logic          ret = 1'b0;
  logic          flag_o;
  logic [CW-1:0] cause_o;
  logic [N-1:0]  pend_o;
  logic          svc_o;

  int_ctrl_arb #(
    .NUM_SRC(N), .CAUSE_W(CW), .CAUSE_TABLE({5'd7, 5'd3, 5'd11}),
    .EDGE_MASK(EM), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_en_i(en), .glb_en_i(glb),
    .inst_valid_i(iv), .ex_exception_flag_i(exf), .ex_exception_cause_i(exc),
    .trap_taken_i(taken), .trap_ret_i(ret),
    .ex_exception_flag_o(flag_o), .ex_exception_cause_o(cause_o),
    .int_pending_o(pend_o), .in_service_o(svc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          flag;
    logic [CW-1:0] cause;
    logic [N-1:0]  pend;
    logic          svc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: irq history stands in for the synchroniser delay.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_prev;
  logic [N-1:0] m_ep;
  logic [N-1:0] edge_v = EM;
  int           m_mode;
  int           m_lat;
  int           cause_of[N] = '{11, 3, 7};

  function automatic void model_reset();
    hist = {};
    for (int i = 0; i < S; i++) hist.push_back('0);
    m_prev = '0;
    m_ep   = '0;
    m_mode = M_IDLE;
    m_lat  = 0;
  endfunction

  function automatic logic [N-1:0] m_pend();
    logic [N-1:0] p;
    logic [N-1:0] s;
    s = hist[0];
    for (int k = 0; k < N; k++) p[k] = edge_v[k] ? m_ep[k] : s[k];
    return p;
  endfunction

  function automatic int lowest_set(logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic cyc();
    exp_t         e;
    logic [N-1:0] p;
    logic [N-1:0] el;
    logic [N-1:0] s;
    int           w;
    if (!rst_n) begin
      e.flag = 1'b0; e.cause = '0; e.pend = '0; e.svc = 1'b0;
    end else begin
      e.flag  = iv & (exf | (m_mode == M_REQ));
      e.cause = (m_mode == M_REQ) ? CW'(cause_of[m_lat]) : exc;
      e.pend  = m_pend();
      e.svc   = (m_mode == M_SVC);
    end
    sbq.push_back(e);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      p  = m_pend();
      el = p & en & {N{glb}};
      w  = lowest_set(el);
      s  = hist[0];
      for (int k = 0; k < N; k++)
        if (edge_v[k])
          m_ep[k] = (s[k] & ~m_prev[k]) |
                    (m_ep[k] & ~((m_mode == M_REQ) && taken && (m_lat == k)));
      m_prev = s;
      hist.push_back(irq);
      void'(hist.pop_front());
      if (m_mode == M_IDLE) begin
        if (w >= 0) begin m_lat = w; m_mode = M_REQ; end
      end else if (m_mode == M_REQ) begin
        if (taken)       m_mode = M_SVC;
        else if (w < 0)  m_mode = M_IDLE;
        else             m_lat  = w;
      end else begin
        if (ret) m_mode = M_IDLE;
      end
    end
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_taken();
    taken = 1'b1; cyc(); taken = 1'b0;
  endtask

  task automatic pulse_ret();
    ret = 1'b1; cyc(); ret = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_cmp++;
      if (flag_o !== e.flag) begin
        n_bad++;
        $display("FAIL flag t=%0t got=%b exp=%b", $time, flag_o, e.flag);
      end
      n_cmp++;
      if (cause_o !== e.cause) begin
        n_bad++;
        $display("FAIL cause t=%0t got=%0d exp=%0d", $time, cause_o, e.cause);
      end
      n_cmp++;
      if (pend_o !== e.pend) begin
        n_bad++;
        $display("FAIL pending t=%0t got=%b exp=%b", $time, pend_o, e.pend);
      end
      n_cmp++;
      if (svc_o !== e.svc) begin
        n_bad++;
        $display("FAIL in_service t=%0t got=%b exp=%b", $time, svc_o, e.svc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t run did not complete", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);

    // Timer only, serviced, then re-requested by the still-high level line
    glb = 1'b1; en = 3'b111; iv = 1'b1; irq = 3'b100;
    cycles(6);
    pulse_taken();
    cycles(2);
    pulse_ret();
    cycles(3);
    irq = 3'b000;
    cycles(4);

    // Priority re-arbitration 7 -> 11
    irq = 3'b100; cycles(4);
    irq = 3'b101; cycles(4);
    pulse_taken(); cycles(1);
    irq = 3'b000; pulse_ret(); cycles(4);

    // Exception merge
    exf = 1'b1; exc = 5'd2; cycles(3);
    irq = 3'b100; cycles(4);
    iv = 1'b0; cycles(2);
    iv = 1'b1; exf = 1'b0; irq = 3'b000; cycles(4);

    // Edge source pulse, clear on take, coincident second edge
    irq = 3'b010; cyc(); irq = 3'b000; cycles(5);
    pulse_taken(); cycles(2);
    pulse_ret(); cycles(2);
    irq = 3'b010; cyc(); irq = 3'b000; cycles(4);
    irq = 3'b010; cyc(); irq = 3'b000; cyc();
    pulse_taken(); cycles(3);
    pulse_ret(); cycles(3);
    pulse_taken(); cycles(1);
    pulse_ret(); cycles(3);

    // Withdraw by enable / global gating, and take coincident with drop
    irq = 3'b100; cycles(4);
    en = 3'b011; cycles(2);
    en = 3'b111; cycles(3);
    glb = 1'b0; cycles(2);
    glb = 1'b1; cycles(3);
    en = 3'b011; taken = 1'b1; cyc(); taken = 1'b0; en = 3'b111;
    cycles(2);
    pulse_ret(); cycles(2);

    // Async reset while in service
    pulse_taken(); cycles(1);
    rst_n = 1'b0; cycles(2);
    rst_n = 1'b1; cycles(4);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) irq = N'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) en = N'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) glb = 1'($urandom_range(0, 3) != 0);
      iv    = 1'($urandom_range(0, 7) != 0);
      exf   = 1'($urandom_range(0, 7) == 0);
      exc   = CW'($urandom_range(0, 31));
      taken = 1'($urandom_range(0, 5) == 0);
      ret   = 1'($urandom_range(0, 5) == 0);
      rst_n = 1'($urandom_range(0, 299) != 0);
      cyc();
    end
    rst_n = 1'b1; taken = 1'b0; ret = 1'b0;
    cycles(3);

    @(negedge clk);
    #1;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain leftover=%0d exp=0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
